// File: rtl/div_if.sv
`default_nettype none
// ==================================================================
// div_if - request/result bundle between the execute stage and div_unit
// Rev 1.0
// ==================================================================
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             sign_i;
  logic             annul_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             stall_o;
  logic             ready_o;
  logic [WIDTH-1:0] quo_o;
  logic [WIDTH-1:0] rem_o;

  modport master (
    output start_i, sign_i, annul_i, a_i, b_i,
    input  stall_o, ready_o, quo_o, rem_o
  );

  modport slave (
    input  start_i, sign_i, annul_i, a_i, b_i,
    output stall_o, ready_o, quo_o, rem_o
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ==================================================================
// div_unit - iterative radix-2 restoring divider for MIPS DIV/DIVU;
// define DIV_EARLY_OUT_EN to finish early on b==0 or |a|<|b|. Rev 1.0
// ==================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] par_q;
  logic [WIDTH-1:0] araw_q;
  logic             negq_q;
  logic             negr_q;
  logic             div0_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             ready_q;

  logic [WIDTH-1:0] a_abs_w;
  logic [WIDTH-1:0] b_abs_w;
  logic [WIDTH:0]   trial_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] par_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_fix_w;
  logic [WIDTH-1:0] rem_fix_w;

  assign a_abs_w = (bus.sign_i & bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
  assign b_abs_w = (bus.sign_i & bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

  // Bring down the next dividend bit, trial-subtract, restore on borrow.
  assign trial_w   = {par_q, dvd_q[WIDTH-1]};
  assign diff_w    = trial_w - {1'b0, dvs_q};
  assign par_d     = diff_w[WIDTH] ? trial_w[WIDTH-1:0] : diff_w[WIDTH-1:0];
  assign dvd_d     = {dvd_q[WIDTH-2:0], ~diff_w[WIDTH]};
  assign quo_fix_w = negq_q ? -dvd_d : dvd_d;
  assign rem_fix_w = negr_q ? -par_d : par_d;

  assign bus.stall_o = ~bus.annul_i &
                       (((state_q == S_IDLE) & bus.start_i) | (state_q == S_BUSY));
  assign bus.ready_o = ready_q;
  assign bus.quo_o   = quo_q;
  assign bus.rem_o   = rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      par_q   <= '0;
      araw_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            dvd_q   <= a_abs_w;
            dvs_q   <= b_abs_w;
            par_q   <= '0;
            araw_q  <= bus.a_i;
            negq_q  <= bus.sign_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
            negr_q  <= bus.sign_i & bus.a_i[WIDTH-1];
            div0_q  <= (bus.b_i == '0);
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.annul_i) begin
            state_q <= S_IDLE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if ((cnt_q == '0) && (div0_q || (dvd_q < dvs_q))) begin
            quo_q   <= div0_q ? '1 : '0;
            rem_q   <= araw_q;
            ready_q <= 1'b1;
            state_q <= S_DONE;
          end
`endif
          else begin
            par_q <= par_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == c_cnt_last) begin
              // Divide-by-zero bypasses sign fixup: LO all ones, HI the raw dividend.
              quo_q   <= div0_q ? '1 : quo_fix_w;
              rem_q   <= div0_q ? araw_q : rem_fix_w;
              ready_q <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ==================================================================
// tb_div_unit - directed vectors against a plain-arithmetic divide model
// Rev 1.0
// ==================================================================
module tb_div_unit;

  localparam int W    = 32;
  localparam int NCYC = 4096;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  div_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          exp_stall [0:NCYC-1];
  bit          exp_ready [0:NCYC-1];
  logic [63:0] exp_res [$];
  logic [31:0] hold_q;
  logic [31:0] hold_r;
  int          last_rdy;
  int          prev_rdy;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Architectural result: truncating division, remainder follows the dividend.
  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint la;
    longint lb;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (s) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = {32'h0, a};
        lb = {32'h0, b};
      end
      q = 32'(la / lb);
      r = 32'(la % lb);
    end
  endfunction

  function automatic int latency(input bit s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ua;
    logic [31:0] ub;
    ua = (s && a[31]) ? -a : a;
    ub = (s && b[31]) ? -b : b;
    if (b == 32'h0 || ua < ub) return 2;
`endif
    return W + 1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    step(n);
  endtask

  // Start a divide in the current cycle; annul_off >= 0 flushes it that many cycles in.
  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input int annul_off);
    int          st;
    int          lat;
    logic [31:0] q;
    logic [31:0] r;
    st  = cyc;
    lat = latency(s, a, b);
    model(s, a, b, q, r);
    bus.start_i = 1'b1;
    bus.sign_i  = s;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.annul_i = 1'b0;
    if (annul_off < 0) begin
      for (int k = 0; k < lat; k++) exp_stall[st + k] = 1'b1;
      exp_ready[st + lat] = 1'b1;
      exp_res.push_back({q, r});
      step(lat + 1);
    end else begin
      for (int k = 0; k < annul_off; k++) exp_stall[st + k] = 1'b1;
      step(annul_off);
      bus.annul_i = 1'b1;
      step(1);
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
    end
  endtask

  task automatic do_div_rst(input bit s, input logic [31:0] a, input logic [31:0] b,
                            input int rst_off);
    int st;
    st = cyc;
    for (int k = 0; k < rst_off; k++) exp_stall[st + k] = 1'b1;
    bus.start_i = 1'b1;
    bus.sign_i  = s;
    bus.a_i     = a;
    bus.b_i     = b;
    step(rst_off);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    hold_q      = 32'h0;
    hold_r      = 32'h0;
    step(2);
    rst = 1'b1;
  endtask

  // Per-cycle compare against the expected schedule and held results.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < NCYC) begin
        if (exp_ready[cyc] && exp_res.size() > 0) begin
          e      = exp_res.pop_front();
          hold_q = e[63:32];
          hold_r = e[31:0];
        end
        check("stall_o", 32'(bus.stall_o), 32'(exp_stall[cyc]));
        check("ready_o", 32'(bus.ready_o), 32'(exp_ready[cyc]));
        check("quo_o", bus.quo_o, hold_q);
        check("rem_o", bus.rem_o, hold_r);
        if (bus.ready_o) begin
          prev_rdy = last_rdy;
          last_rdy = cyc;
        end
      end
    end
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    hold_q      = 32'h0;
    hold_r      = 32'h0;
    last_rdy    = -1;
    prev_rdy    = -1;
    rst         = 1'b0;
    bus.start_i = 1'b0;
    bus.sign_i  = 1'b0;
    bus.annul_i = 1'b0;
    bus.a_i     = 32'h0;
    bus.b_i     = 32'h0;
    for (int i = 0; i < NCYC; i++) begin
      exp_stall[i] = 1'b0;
      exp_ready[i] = 1'b0;
    end

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[7]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[10] = '{1'b0, 32'd9,          32'd4,          32'd2,          32'd1};

    step(2);
    rst = 1'b1;
    idle(2);

    for (int i = 0; i < 11; i++) begin
      do_div(vecs[i].s, vecs[i].a, vecs[i].b, -1);
      check("vec_quo", bus.quo_o, vecs[i].q);
      check("vec_rem", bus.rem_o, vecs[i].r);
      idle(2);
    end

    // Flushed request in IDLE must not start anything.
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.a_i     = 32'd50;
    bus.b_i     = 32'd3;
    step(1);
    idle(3);

    // Annul mid-divide, then a fresh divide.
    do_div(1'b0, 32'd100, 32'd7, 10);
    idle(3);
    do_div(1'b0, 32'd9, 32'd4, -1);
    check("after_annul_quo", bus.quo_o, 32'd2);
    check("after_annul_rem", bus.rem_o, 32'd1);
    idle(2);

    // Back-to-back with start held through DONE.
    do_div(1'b0, 32'd100, 32'd7, -1);
    do_div(1'b0, 32'd9, 32'd4, -1);
    idle(2);
    check("b2b_ready_gap", 32'(last_rdy - prev_rdy), 32'd34);
    check("b2b_quo", bus.quo_o, 32'd2);
    check("b2b_rem", bus.rem_o, 32'd1);

    // Reset in the middle of a divide.
    do_div_rst(1'b0, 32'd100, 32'd7, 15);
    check("rst_quo", bus.quo_o, 32'd0);
    check("rst_rem", bus.rem_o, 32'd0);
    idle(2);
    do_div(1'b0, 32'd3, 32'd10, -1);
    check("post_rst_quo", bus.quo_o, 32'd0);
    check("post_rst_rem", bus.rem_o, 32'd3);
    idle(4);

    check("pending_results", 32'(exp_res.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
